image_loader: RTL and testbench
===============================

IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameters SHALL be: H, default 24, image rows; W, default 24, image columns; DATA_BITS, default 8, pixel width; ADDR_BITS, default 10, memory address width.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 start_i  input  1  one-cycle frame start request.
REQ-005 base_addr_i  input  ADDR_BITS  address of pixel (0,0); sampled when a start is accepted.
REQ-006 mem_ren_o  output  1  memory read strobe.
REQ-007 mem_addr_o  output  ADDR_BITS  memory read address.
REQ-008 mem_rdata_i  input  DATA_BITS  read data, valid exactly 1 cycle after mem_ren_o.
REQ-009 fifo_wen_o  output  1  input-FIFO write strobe.
REQ-010 fifo_wdata_o  output  DATA_BITS  input-FIFO write data.
REQ-011 fifo_full_i  input  1  input-FIFO full flag.
REQ-012 busy_o  output  1  high while a frame is in progress.
REQ-013 done_o  output  1  one-cycle pulse when the last pixel of a frame has been written.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, DRAIN: IDLE->RUN on start_i; RUN->DRAIN when the last read is issued; DRAIN->IDLE when buffer empty and no read in flight, asserting done_o in that same cycle.
REQ-015 start_i SHALL be ignored outside IDLE.
REQ-016 Pixels SHALL be read row-major; address = base + r*W + c, incrementing by 1 per read, H*W reads per frame.
REQ-017 Read data SHALL land in a 2-entry in-order buffer; fifo_wen_o = (buffer non-empty) AND NOT fifo_full_i, fifo_wdata_o = oldest entry.
REQ-018 A read SHALL issue only in RUN and when (occupancy + in-flight - write-this-cycle) <= 1; no buffer overflow and no data loss under any fifo_full_i pattern.
REQ-019 With fifo_full_i held low, throughput SHALL be 1 pixel/cycle; first fifo_wen_o occurs 2 cycles after the start-accept cycle.
REQ-020 fifo_full_i asserting mid-frame SHALL stall writes and, within one cycle, reads; deassertion SHALL resume without gap or duplication.
REQ-021 Read in flight and buffer write in the same cycle SHALL both be honoured (occupancy +1 -1).
REQ-022 busy_o SHALL be high from the cycle after start accept through the done_o cycle inclusive.
REQ-023 Back-to-back frames: start_i in the cycle after done_o SHALL be accepted.

Reset
REQ-024 On resetn low, immediately: state IDLE; mem_ren_o, fifo_wen_o, busy_o, done_o = 0; mem_addr_o, fifo_wdata_o = 0; buffer emptied, in-flight cleared.
REQ-025 Reset mid-frame SHALL abort the frame; data returning after reset release SHALL be discarded; no done_o.

Configuration
REQ-026 Macro IMAGE_LOADER_ZERO_PAD_EN: when defined, the frame SHALL be (H+2)x(W+2) pixels, border pixels = 0 inserted into the buffer without a memory read, only when no read is in flight (order preserved), interior read at base + (r-1)*W + (c-1); when undefined, H*W pixels, no padding logic.

Verification
REQ-027 H=W=4, base 0x010, full low, start -> 16 reads 0x010..0x01F, 16 writes matching memory, done_o 1 cycle after last write, busy_o then low.
REQ-028 fifo_full_i high cycles 5-9 of frame -> no fifo_wen_o in those cycles, at most 2 reads past stall onset, output sequence identical to REQ-027.
REQ-029 start_i pulsed during RUN -> ignored, single 16-pixel frame; start_i in cycle after done_o -> second frame accepted.
REQ-030 resetn low after 7 writes, released, start -> all outputs 0 during reset, new frame begins at base, exactly 16 writes.
REQ-031 ZERO_PAD_EN, H=W=4 -> 36 writes, rows 0/5 and cols 0/5 zero, 16 reads, interior order correct.
REQ-032 Random fifo_full_i (50%), H=W=24 -> 576 writes in order, no drop/duplicate, one done_o.

Source files
------------

// File: rtl/image_loader.sv
// image_loader: streams an H x W frame from a 1-cycle-latency memory into an
// input FIFO through a 2-entry in-order skid buffer, one pixel per cycle.
//
// Optional feature macro: IMAGE_LOADER_ZERO_PAD_EN
//   defined   -> (H+2) x (W+2) frame with a zero border inserted locally
//   undefined -> plain H x W frame
//
// Ports:
//   clk, resetn       clock, asynchronous active-low reset
//   start_i           one-cycle frame start request (honoured in IDLE only)
//   base_addr_i       address of pixel (0,0), sampled on start accept
//   mem_ren_o         memory read strobe
//   mem_addr_o        memory read address
//   mem_rdata_i       read data, valid one cycle after mem_ren_o
//   fifo_wen_o        input-FIFO write strobe
//   fifo_wdata_o      input-FIFO write data (oldest buffered pixel)
//   fifo_full_i       input-FIFO full flag
//   busy_o            frame in progress
//   done_o            one-cycle pulse after the last pixel is written
module image_loader #(
    parameter int H         = 24,
    parameter int W         = 24,
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic [ADDR_BITS-1:0] base_addr_i,
    output logic                 mem_ren_o,
    output logic [ADDR_BITS-1:0] mem_addr_o,
    input  logic [DATA_BITS-1:0] mem_rdata_i,
    output logic                 fifo_wen_o,
    output logic [DATA_BITS-1:0] fifo_wdata_o,
    input  logic                 fifo_full_i,
    output logic                 busy_o,
    output logic                 done_o
);

`ifdef IMAGE_LOADER_ZERO_PAD_EN
    localparam int ROWS = H + 2;
    localparam int COLS = W + 2;
`else
    localparam int ROWS = H;
    localparam int COLS = W;
`endif

    localparam int RW = ($clog2(ROWS + 1) < 1) ? 1 : $clog2(ROWS + 1);
    localparam int CW = ($clog2(COLS + 1) < 1) ? 1 : $clog2(COLS + 1);

    localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [RW-1:0]        row_q;
    logic [CW-1:0]        col_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [DATA_BITS-1:0] buf_q [2];
    logic                 head_q;
    logic [1:0]           occ_q;
    logic                 inflight_q;

    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic [2:0]           load;
    logic                 room;
    logic                 issue;
    logic                 rd_issue;
    logic                 pad_push;
    logic                 bypass;
    logic                 pop;
    logic                 land_push;
    logic                 push;
    logic [DATA_BITS-1:0] push_data;
    logic                 last_pix;
    logic                 drain_done;
    logic                 accept;
`ifdef IMAGE_LOADER_ZERO_PAD_EN
    logic                 border;
`endif

    // Datapath control. Returning read data bypasses the buffer when the
    // buffer is empty and the FIFO can take it, which gives the 2-cycle
    // start-to-first-write latency and 1 pixel/cycle in steady state.
    always_comb begin
        wr_en      = ((occ_q != 2'd0) || inflight_q) && !fifo_full_i;
        wr_data    = '0;
        if (occ_q != 2'd0) begin
            wr_data = buf_q[head_q];
        end else if (inflight_q) begin
            wr_data = mem_rdata_i;
        end
        // Entries committed after this cycle must never exceed two.
        load       = {1'b0, occ_q} + {2'b00, inflight_q};
        room       = load <= ({2'b00, wr_en} + 3'd1);
        last_pix   = (row_q == R_LAST) && (col_q == C_LAST);
        drain_done = (occ_q == 2'd0) && !inflight_q;
        accept     = (state_q == IDLE) && start_i;
`ifdef IMAGE_LOADER_ZERO_PAD_EN
        border     = (row_q == '0) || (row_q == R_LAST) ||
                     (col_q == '0) || (col_q == C_LAST);
        // A zero can only be inserted once the previous read has landed,
        // otherwise it would overtake that pixel.
        issue      = (state_q == RUN) && room &&
                     (!border || !inflight_q);
        rd_issue   = issue && !border;
        pad_push   = issue && border;
`else
        issue      = (state_q == RUN) && room;
        rd_issue   = issue;
        pad_push   = 1'b0;
`endif
        bypass     = wr_en && (occ_q == 2'd0);
        pop        = wr_en && (occ_q != 2'd0);
        land_push  = inflight_q && !bypass;
        push       = land_push || pad_push;
`ifdef IMAGE_LOADER_ZERO_PAD_EN
        push_data  = land_push ? mem_rdata_i : '0;
`else
        push_data  = mem_rdata_i;
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (issue && last_pix) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        mem_ren_o    = rd_issue;
        mem_addr_o   = addr_q;
        fifo_wen_o   = wr_en;
        fifo_wdata_o = wr_data;
        busy_o       = (state_q != IDLE);
        done_o       = (state_q == DRAIN) && drain_done;
    end

    // Pixel counters and read address
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
        end else if (accept) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= base_addr_i;
        end else if (issue) begin
            if (col_q == C_LAST) begin
                col_q <= '0;
                row_q <= row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
            if (rd_issue) begin
                addr_q <= addr_q + ADDR_BITS'(1);
            end
        end
    end

    // In-flight flag and 2-entry buffer. With two entries held and a
    // simultaneous push/pop, the push lands in the slot being vacated.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
            occ_q      <= 2'd0;
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
        end else begin
            inflight_q <= rd_issue;
            if (push) begin
                buf_q[head_q ^ occ_q[0]] <= push_data;
            end
            if (pop) begin
                head_q <= ~head_q;
            end
            unique case ({push, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

endmodule

// File: tb/tb_image_loader.sv
// Directed bench for image_loader: a 4x4 instance for the directed cases and
// a 24x24 instance for a long run under a random FIFO-full pattern.
module tb_image_loader;

    localparam int SH = 4;
    localparam int SW = 4;
    localparam int BH = 24;
    localparam int BW = 24;
    localparam int DB = 8;
    localparam int AB = 10;
    localparam int BBASE = 32;

`ifdef IMAGE_LOADER_ZERO_PAD_EN
    localparam int NP  = (SH + 2) * (SW + 2);
    localparam int BNP = (BH + 2) * (BW + 2);
`else
    localparam int NP  = SH * SW;
    localparam int BNP = BH * BW;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          s_start, s_ren, s_wen, s_full, s_busy, s_done;
    logic [AB-1:0] s_base, s_addr;
    logic [DB-1:0] s_rdata = '0;
    logic [DB-1:0] s_wdata;

    logic          b_start, b_ren, b_wen, b_full, b_busy, b_done;
    logic [AB-1:0] b_base, b_addr;
    logic [DB-1:0] b_rdata = '0;
    logic [DB-1:0] b_wdata;

    image_loader #(.H(SH), .W(SW), .DATA_BITS(DB), .ADDR_BITS(AB)) dut (
        .clk(clk), .resetn(resetn), .start_i(s_start),
        .base_addr_i(s_base), .mem_ren_o(s_ren), .mem_addr_o(s_addr),
        .mem_rdata_i(s_rdata), .fifo_wen_o(s_wen), .fifo_wdata_o(s_wdata),
        .fifo_full_i(s_full), .busy_o(s_busy), .done_o(s_done)
    );

    image_loader #(.H(BH), .W(BW), .DATA_BITS(DB), .ADDR_BITS(AB)) dut_big (
        .clk(clk), .resetn(resetn), .start_i(b_start),
        .base_addr_i(b_base), .mem_ren_o(b_ren), .mem_addr_o(b_addr),
        .mem_rdata_i(b_rdata), .fifo_wen_o(b_wen), .fifo_wdata_o(b_wdata),
        .fifo_full_i(b_full), .busy_o(b_busy), .done_o(b_done)
    );

    function automatic logic [DB-1:0] pix(input logic [AB-1:0] a);
        logic [15:0] t;
        t = 16'(a) * 16'd37 + 16'd11;
        return t[DB-1:0];
    endfunction

    function automatic logic [DB-1:0] exp_pix(input int base, input int i,
                                              input int h, input int w);
`ifdef IMAGE_LOADER_ZERO_PAD_EN
        int r, c;
        r = i / (w + 2);
        c = i % (w + 2);
        if (r == 0 || r == h + 1 || c == 0 || c == w + 1) return '0;
        return pix(AB'(base + (r - 1) * w + (c - 1)));
`else
        return pix(AB'(base + i));
`endif
    endfunction

    // memories with one cycle of read latency
    always @(posedge clk) if (s_ren) s_rdata <= pix(s_addr);
    always @(posedge clk) if (b_ren) b_rdata <= pix(b_addr);

    logic [DB-1:0] wq[$];
    logic [AB-1:0] rq[$];
    int first_wen, last_wen, first_busy, done_cnt, done_cyc;
    int stall_reads, wen_in_full;
    int done_busy;

    always @(negedge clk) begin
        if (resetn) begin
            if (s_wen) begin
                wq.push_back(s_wdata);
                if (first_wen < 0) first_wen = cyc;
                last_wen = cyc;
                if (s_full) wen_in_full++;
            end
            if (s_ren) begin
                rq.push_back(s_addr);
                if (s_full) stall_reads++;
            end
            if (s_busy && first_busy < 0) first_busy = cyc;
            if (s_done) begin
                done_cnt++;
                done_cyc = cyc;
                done_busy = int'(s_busy);
            end
        end
    end

    int b_wcnt = 0, b_rcnt = 0, b_derr = 0, b_aerr = 0, b_done_cnt = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (b_wen) begin
                if (b_wdata !== exp_pix(BBASE, b_wcnt, BH, BW)) b_derr++;
                b_wcnt++;
            end
            if (b_ren) begin
                if (b_addr !== AB'(BBASE + b_rcnt)) b_aerr++;
                b_rcnt++;
            end
            if (b_done) b_done_cnt++;
        end
    end

    int n_assert = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wq.delete();
        rq.delete();
        first_wen = -1;
        last_wen = -1;
        first_busy = -1;
        done_cnt = 0;
        done_cyc = -1;
        done_busy = 0;
        stall_reads = 0;
        wen_in_full = 0;
    endtask

    task automatic start_frame(input logic [AB-1:0] base);
        s_base = base;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
    endtask

    // Called in the first RUN cycle; fifo_full_i is high for frame
    // cycles lo..hi. Returns mid-way through the done_o cycle.
    task automatic run_small(input string tag, input int lo, input int hi,
                             input int budget);
        int ok;
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            s_full = (k >= lo && k <= hi);
            if (s_done) begin
                ok = 1;
                break;
            end
            step();
        end
        s_full = 1'b0;
        chk({tag, "_done_seen"}, ok, 1);
        @(negedge clk);
        #1;
    endtask

    task automatic check_seq(input string tag, input int base,
                             input int roff, input int woff);
        int ea, ed;
        ea = 0;
        ed = 0;
        for (int i = 0; i < SH * SW; i++)
            if (roff + i >= rq.size() || rq[roff + i] !== AB'(base + i)) ea++;
        for (int i = 0; i < NP; i++)
            if (woff + i >= wq.size() ||
                wq[woff + i] !== exp_pix(base, i, SH, SW)) ed++;
        chk({tag, "_addr_seq"}, ea, 0);
        chk({tag, "_data_seq"}, ed, 0);
    endtask

    int a;
    int ok;

    initial begin
        s_start = 0; s_base = '0; s_full = 0;
        b_start = 0; b_base = '0; b_full = 0;
        clr();

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", {s_ren, s_wen, s_busy, s_done,
                         b_ren, b_wen, b_busy, b_done}, 0);
        chk("rst_addr", 32'(s_addr), 0);
        chk("rst_wdata", 32'(s_wdata), 0);
        @(posedge clk);
        #1 resetn = 1'b1;
        step();

        // basic frame, FIFO never full
        clr();
        start_frame(10'h010);
        a = cyc;
        run_small("t1", -1, -1, 200);
        chk("t1_reads", rq.size(), SH * SW);
        chk("t1_writes", wq.size(), NP);
        check_seq("t1", 'h010, 0, 0);
        chk("t1_first_busy", first_busy, a);
        chk("t1_first_wen", first_wen, a + 1);
        chk("t1_done_lat", done_cyc, last_wen + 1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_busy_at_done", done_busy, 1);
`ifndef IMAGE_LOADER_ZERO_PAD_EN
        chk("t1_throughput", last_wen - first_wen, NP - 1);
`endif
        step();
        chk("t1_idle_after", 32'(s_busy), 0);

        // FIFO full during frame cycles 5..9
        step();
        clr();
        start_frame(10'h010);
        run_small("t2", 5, 9, 200);
        chk("t2_wen_in_full", wen_in_full, 0);
        chk("t2_stall_reads_le2", 32'(stall_reads <= 2), 1);
        chk("t2_writes", wq.size(), NP);
        check_seq("t2", 'h010, 0, 0);
        chk("t2_done_cnt", done_cnt, 1);

        // start ignored in RUN, then back-to-back start after done
        step();
        clr();
        start_frame(10'h010);
        repeat (4) step();
        s_base = 10'h100;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        run_small("t3a", -1, -1, 200);
        chk("t3_reads_one_frame", rq.size(), SH * SW);
        check_seq("t3a", 'h010, 0, 0);
        chk("t3_done_cnt1", done_cnt, 1);
        step();
        start_frame(10'h040);
        run_small("t3b", -1, -1, 200);
        chk("t3_reads_two_frames", rq.size(), 2 * SH * SW);
        chk("t3_writes_two_frames", wq.size(), 2 * NP);
        check_seq("t3b", 'h040, SH * SW, NP);
        chk("t3_done_cnt2", done_cnt, 2);

        // reset after 7 writes, then a fresh frame
        step();
        clr();
        start_frame(10'h010);
        for (int k = 0; k < 100 && wq.size() < 7; k++) step();
        chk("t4_pre_wcnt", wq.size(), 7);
        resetn = 1'b0;
        #1;
        chk("t4_rst_ctrl", {s_ren, s_wen, s_busy, s_done}, 0);
        chk("t4_rst_addr", 32'(s_addr), 0);
        chk("t4_rst_wdata", 32'(s_wdata), 0);
        chk("t4_no_done", done_cnt, 0);
        step();
        step();
        resetn = 1'b1;
        step();
        clr();
        start_frame(10'h020);
        run_small("t4", -1, -1, 200);
        chk("t4_reads", rq.size(), SH * SW);
        chk("t4_writes", wq.size(), NP);
        check_seq("t4", 'h020, 0, 0);
        chk("t4_done_cnt", done_cnt, 1);

        // 24x24 frame under a random FIFO-full pattern
        step();
        b_base = AB'(BBASE);
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        ok = 0;
        for (int k = 0; k < 5000; k++) begin
            b_full = 1'($urandom_range(0, 1));
            if (b_done) begin
                ok = 1;
                break;
            end
            step();
        end
        b_full = 1'b0;
        chk("t5_done_seen", ok, 1);
        step();
        chk("t5_writes", b_wcnt, BNP);
        chk("t5_reads", b_rcnt, BH * BW);
        chk("t5_data_err", b_derr, 0);
        chk("t5_addr_err", b_aerr, 0);
        chk("t5_done_cnt", b_done_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
